// File: rtl/canny_output_framer_pkg.sv
// Shared definitions for the canny output framer.
// Holds the default frame geometry, the counter widths derived from it,
// the framer FSM state encoding and a width helper for parameterised ports.
package canny_output_framer_pkg;

    localparam int unsigned WIDTH_DEFAULT  = 1280;
    localparam int unsigned HEIGHT_DEFAULT = 720;

    localparam int unsigned X_BITS = $clog2(WIDTH_DEFAULT);
    localparam int unsigned Y_BITS = $clog2(HEIGHT_DEFAULT);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } state_e;

    // Counter width for a dimension; never narrower than one bit.
    function automatic int unsigned bits_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/canny_skid_fifo.sv
// Small synchronous FIFO with show-ahead head.
// Ports:
//   clock, reset        single clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     write an entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head                current head entry, valid while empty=0
//   full, empty, count  occupancy status
module canny_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 25
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_q == COUNT_FULL);
        empty   = (count_q == '0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head    = mem[rd_ptr_q];
        count   = count_q;
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/canny_output_framer.sv
// Canny output framer: pops edge pixels from the canny output FIFO, replicates
// each to SYMBOLS_PER_BEAT symbols, tags the last pixel of each frame with
// end_of_video and streams beats to the VIP encoder through a skid FIFO.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   enable                       start/continue framing, sampled at frame boundaries
//   img_out_empty, img_out_dout  canny output FIFO status and show-ahead head
//   img_out_rd_en                pop the canny output FIFO
//   stall_out                    encoder back-pressure
//   write, data_out              beat transfer strobe and {pix,pix,pix}
//   end_of_video_out             final beat of the frame
//   pixel_x, pixel_y             position of the next pixel to pop
//   frame_done                   1-cycle pulse after the end_of_video beat is written
module canny_output_framer
    import canny_output_framer_pkg::*;
#(
    parameter int unsigned WIDTH            = WIDTH_DEFAULT,
    parameter int unsigned HEIGHT           = HEIGHT_DEFAULT,
    parameter int unsigned BITS_PER_SYMBOL  = 8,
    parameter int unsigned SYMBOLS_PER_BEAT = 3,
    parameter int unsigned SKID_DEPTH       = 4
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic                                        img_out_empty,
    input  logic [BITS_PER_SYMBOL-1:0]                  img_out_dout,
    output logic                                        img_out_rd_en,
    input  logic                                        stall_out,
    output logic                                        write,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data_out,
    output logic                                        end_of_video_out,
    output logic [bits_for(WIDTH)-1:0]                  pixel_x,
    output logic [bits_for(HEIGHT)-1:0]                 pixel_y,
    output logic                                        frame_done
);

    localparam int unsigned DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int unsigned XB = bits_for(WIDTH);
    localparam int unsigned YB = bits_for(HEIGHT);
    localparam logic [XB-1:0] X_LAST = XB'(WIDTH - 1);
    localparam logic [YB-1:0] Y_LAST = YB'(HEIGHT - 1);

    state_e          state_q;
    logic [XB-1:0]   x_q;
    logic [YB-1:0]   y_q;
    logic            frame_done_q;
    logic [DW:0]     last_beat_q;

    logic            eov_pix;
    logic [DW:0]     push_data;
    logic [DW:0]     skid_head;
    logic            skid_full;
    logic            skid_empty;
    logic [$clog2(SKID_DEPTH):0] skid_count;

    always_comb begin
        eov_pix   = (x_q == X_LAST) && (y_q == Y_LAST);
        push_data = {eov_pix, {SYMBOLS_PER_BEAT{img_out_dout}}};
        // Both strobes are masked during reset so no pixel is lost upstream
        // and no beat is emitted while the skid is being discarded.
        img_out_rd_en = (state_q == StStream) & ~img_out_empty & ~skid_full & ~reset;
        write         = ~skid_empty & ~stall_out & ~reset;
        // Once the skid runs dry the last written beat is held on the bus.
        if (skid_empty) begin
            data_out         = last_beat_q[DW-1:0];
            end_of_video_out = last_beat_q[DW];
        end else begin
            data_out         = skid_head[DW-1:0];
            end_of_video_out = skid_head[DW];
        end
        pixel_x    = x_q;
        pixel_y    = y_q;
        frame_done = frame_done_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            last_beat_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (write) begin
                last_beat_q <= skid_head;
            end
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (img_out_rd_en) begin
                        if (eov_pix) begin
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= StDrain;
                        end else if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= y_q + YB'(1);
                        end else begin
                            x_q <= x_q + XB'(1);
                        end
                    end
                end
                StDrain: begin
                    // The frame is over only when its tagged beat leaves the skid.
                    if (write && skid_head[DW]) begin
                        frame_done_q <= 1'b1;
                        state_q      <= enable ? StStream : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    canny_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DW + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (img_out_rd_en),
        .push_data (push_data),
        .pop       (write),
        .head      (skid_head),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    logic unused_count;
    assign unused_count = ^skid_count;

endmodule
